sram_arbiter: RTL

- Shares the board's single 16-bit asynchronous SRAM between two byte-wide requesters and sequences its CE/OE/WE/UB/LB strobes.
  - Port A: floppy CPU bus.
  - Port B: host/debug loader, e.g. UART-fed image upload.
- Sits between the requesters and the top-level SRAM pins. The DQ tristate buffer stays at top level, driven from sram_dq_o/sram_dq_oe.
- Runs on clk24. Requester clock-enables are the requesters' own concern; the arbiter runs every cycle.

---
 rtl/sram_arb_pkg.sv | 15 +
 rtl/sram_req_latch.sv | 47 ++++
 rtl/sram_arbiter.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-port async SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, TURN} state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  localparam int ADDR_W = 19;
  localparam int DATA_W = 8;

  localparam int DEF_RD_CYCLES = 2;
  localparam int DEF_WR_CYCLES = 2;

endpackage

// File: rtl/sram_req_latch.sv
// One requester's pending flag with the write/address/data captured on its strobe.
module sram_req_latch
  import sram_arb_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_clr,
  output logic              o_pending,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_addr,
  output logic [DATA_W-1:0] o_wdata
);

  logic              r_pending;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pending <= 1'b0;
    end else if (i_clr) begin
      r_pending <= 1'b0;
    end else if (i_req) begin
      r_pending <= 1'b1;
    end
  end

  // A strobe arriving while a request is already held is dropped entirely.
  always_ff @(posedge clk) begin
    if (i_req && !r_pending) begin
      r_we    <= i_we;
      r_addr  <= i_addr;
      r_wdata <= i_wdata;
    end
  end

  assign o_pending = r_pending;
  assign o_we      = r_we;
  assign o_addr    = r_addr;
  assign o_wdata   = r_wdata;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one 16-bit async SRAM between two byte-wide requesters;
// all SRAM strobes are registered from the next-state decode so the pins never glitch.
module sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int RD_CYCLES = DEF_RD_CYCLES,
  parameter int WR_CYCLES = DEF_WR_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [18:0] a_addr,
  input  logic [7:0]  a_wdata,
  output logic [7:0]  a_rdata,
  output logic        a_ack,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [18:0] b_addr,
  input  logic [7:0]  b_wdata,
  output logic [7:0]  b_rdata,
  output logic        b_ack,
  output logic [17:0] sram_addr,
  input  logic [15:0] sram_dq_i,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n,
  output logic        busy
);

  localparam logic [3:0] RD_LOAD = 4'(RD_CYCLES - 1);
  localparam logic [3:0] WR_LOAD = 4'(WR_CYCLES - 1);

  logic        w_a_pend, w_a_we, w_a_clr;
  logic [18:0] w_a_addr;
  logic [7:0]  w_a_wdata;
  logic        w_b_pend, w_b_we, w_b_clr;
  logic [18:0] w_b_addr;
  logic [7:0]  w_b_wdata;

  sram_req_latch u_lat_a (
    .clk(clk), .reset(reset), .i_req(a_req), .i_we(a_we), .i_addr(a_addr),
    .i_wdata(a_wdata), .i_clr(w_a_clr), .o_pending(w_a_pend), .o_we(w_a_we),
    .o_addr(w_a_addr), .o_wdata(w_a_wdata)
  );

  sram_req_latch u_lat_b (
    .clk(clk), .reset(reset), .i_req(b_req), .i_we(b_we), .i_addr(b_addr),
    .i_wdata(b_wdata), .i_clr(w_b_clr), .o_pending(w_b_pend), .o_we(w_b_we),
    .o_addr(w_b_addr), .o_wdata(w_b_wdata)
  );

  state_t      r_state, w_next;
  logic        r_last, r_port, r_we, r_lane;
  logic [3:0]  r_cnt;
  logic [17:0] r_sram_addr;
  logic [15:0] r_dq_o;
  logic        r_dq_oe, r_ce_n, r_oe_n, r_we_n, r_ub_n, r_lb_n;
  logic        r_a_ack, r_b_ack;
  logic [7:0]  r_a_rdata, r_b_rdata;

  logic        w_grant, w_gport, w_g_we, w_nx_we, w_nx_lane;
  logic [18:0] w_g_addr;
  logic [7:0]  w_g_wdata, w_rd_byte;

  // On a tie the port that was not served last wins.
  assign w_gport   = (w_a_pend && w_b_pend) ? ~r_last : (w_a_pend ? PORT_A : PORT_B);
  assign w_grant   = (r_state == IDLE) && (w_a_pend || w_b_pend);
  assign w_a_clr   = w_grant && (w_gport == PORT_A);
  assign w_b_clr   = w_grant && (w_gport == PORT_B);
  assign w_g_we    = (w_gport == PORT_A) ? w_a_we    : w_b_we;
  assign w_g_addr  = (w_gport == PORT_A) ? w_a_addr  : w_b_addr;
  assign w_g_wdata = (w_gport == PORT_A) ? w_a_wdata : w_b_wdata;
  assign w_nx_we   = w_grant ? w_g_we      : r_we;
  assign w_nx_lane = w_grant ? w_g_addr[0] : r_lane;
  assign w_rd_byte = r_lane ? sram_dq_i[15:8] : sram_dq_i[7:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_a_pend || w_b_pend) w_next = SETUP;
      SETUP:   w_next = ACCESS;
      ACCESS:  if (r_cnt == 4'd0) w_next = TURN;
      TURN:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_last      <= PORT_B;
      r_port      <= PORT_A;
      r_we        <= 1'b0;
      r_lane      <= 1'b0;
      r_cnt       <= 4'd0;
      r_sram_addr <= '0;
      r_dq_o      <= '0;
      r_dq_oe     <= 1'b0;
      r_ce_n      <= 1'b1;
      r_oe_n      <= 1'b1;
      r_we_n      <= 1'b1;
      r_ub_n      <= 1'b1;
      r_lb_n      <= 1'b1;
      r_a_ack     <= 1'b0;
      r_b_ack     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_rdata   <= '0;
    end else begin
      if (w_grant) begin
        r_last      <= w_gport;
        r_port      <= w_gport;
        r_we        <= w_g_we;
        r_lane      <= w_g_addr[0];
        r_sram_addr <= w_g_addr[18:1];
        if (w_g_we) r_dq_o <= {w_g_wdata, w_g_wdata};
      end
      if (r_state == SETUP) begin
        r_cnt <= r_we ? WR_LOAD : RD_LOAD;
      end else if ((r_state == ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Read data is sampled on the edge that closes the last OE-low cycle.
      if ((r_state == ACCESS) && (r_cnt == 4'd0) && !r_we) begin
        if (r_port == PORT_A) r_a_rdata <= w_rd_byte;
        else                  r_b_rdata <= w_rd_byte;
      end
      r_ce_n  <= (w_next == IDLE);
      r_oe_n  <= !((w_next == ACCESS) && !w_nx_we);
      r_we_n  <= !((w_next == ACCESS) && w_nx_we);
      r_lb_n  <= (w_next == IDLE) || w_nx_lane;
      r_ub_n  <= (w_next == IDLE) || !w_nx_lane;
      r_dq_oe <= (w_next != IDLE) && w_nx_we;
      r_a_ack <= (w_next == TURN) && (r_port == PORT_A);
      r_b_ack <= (w_next == TURN) && (r_port == PORT_B);
    end
  end

  assign sram_addr  = r_sram_addr;
  assign sram_dq_o  = r_dq_o;
  assign sram_dq_oe = r_dq_oe;
  assign sram_ce_n  = r_ce_n;
  assign sram_oe_n  = r_oe_n;
  assign sram_we_n  = r_we_n;
  assign sram_ub_n  = r_ub_n;
  assign sram_lb_n  = r_lb_n;
  assign a_ack      = r_a_ack;
  assign b_ack      = r_b_ack;
  assign a_rdata    = r_a_rdata;
  assign b_rdata    = r_b_rdata;
  assign busy       = (r_state != IDLE);

endmodule
